kyber_bus_master: RTL
=====================

Name: kyber_bus_master

Overview:
- Host-side bus master that sits directly upstream of the Kyber top-level bus slave.
- Accepts 32-bit read/write requests on a valid/ready stream and buffers them in a small request FIFO.
- Issues requests one at a time on the bus_enable/bus_write/bus_addr/bus_wdata bus and waits for the slave's one-cycle bus_ready pulse.
- Returns read data or write acknowledgement on a valid/ready response stream. A timeout guards against a slave that never responds.

Parameters:
- FIFO_DEPTH, 4, request FIFO entries; power of two, minimum 2.
- TIMEOUT_CYCLES, 64, maximum number of ISSUE cycles without bus_ready before the transaction is aborted; minimum 4.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  host request valid.
- req_ready  out  1  request FIFO not full.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  32  bus address.
- req_wdata  in  32  write data; ignored for reads.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  host accepts response.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_write  out  1  echo of the request type.
- rsp_err  out  1  1 = transaction timed out.
- bus_enable  out  1  transaction strobe to slave.
- bus_write  out  1  write qualifier.
- bus_addr  out  32  address.
- bus_wdata  out  32  write data.
- bus_rdata  in  32  slave read data; valid in the bus_ready cycle.
- bus_ready  in  1  slave completion pulse, one cycle.
- busy  out  1  high when the FIFO is non-empty or the state is not IDLE.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all outputs 0 except req_ready=1. The FIFO is emptied, state=IDLE, timeout counter=0.
- Asserting rst mid-transaction drops bus_enable immediately. Any pending or in-flight request is discarded and no response is produced.
- Request FIFO:
  - Push when req_valid && req_ready. req_ready = !full, registered from the pointers.
  - Pop occurs only on the IDLE->ISSUE transition. Push and pop in the same cycle are both allowed; the occupancy is unchanged.
  - When full, req_ready=0 and no push occurs, regardless of a same-cycle pop.
  - The FIFO uses a count-based full/empty scheme. Pointers wrap modulo FIFO_DEPTH.
- State machine (registered outputs):
  - IDLE:
    - If the FIFO is non-empty, load the head entry into bus_write/bus_addr/bus_wdata and set bus_enable=1; go to ISSUE.
    - Otherwise bus_enable=0.
  - ISSUE:
    - Hold bus_enable and all bus fields stable. The timeout counter increments every cycle.
    - If bus_ready=1: bus_enable<=0. Capture rsp_rdata<=bus_rdata for reads, 0 for writes. Set rsp_write, rsp_err<=0, rsp_valid<=1, and go to RESP.
    - Else if the counter reaches TIMEOUT_CYCLES-1: bus_enable<=0, rsp_rdata<=0, rsp_err<=1, rsp_valid<=1; go to RESP.
    - If bus_ready arrives on the same cycle the counter reaches its limit, bus_ready wins and rsp_err=0.
  - RESP:
    - Hold the response until rsp_valid && rsp_ready, then clear rsp_valid and go to IDLE. The counter is cleared.
    - rsp_ready held high still costs one RESP cycle.
- Bus guarantees:
  - bus_enable is low for at least 2 cycles between consecutive transactions: the RESP cycle plus the IDLE cycle. This ensures the slave has deasserted bus_ready before the next strobe.
  - A bus_ready seen outside ISSUE is ignored.
  - Exactly one transaction is outstanding at a time.
- Latency with a responsive host, counting request handshake at edge E0:
  - bus_enable is high after E2.
  - For a single-cycle slave (bus_ready high after E3), rsp_valid is high after E4.
- Ordering: responses are returned strictly in request order, one response per request including timeouts.
- busy covers the FIFO, ISSUE and RESP states.

Test Plan:
- Reset, then write addr 0x0010 data 0x15 with the slave model answering 1 cycle after enable. Required: enable held for exactly 2 cycles; rsp_valid with rsp_write=1, rsp_err=0, rsp_rdata=0; bus_addr=0x10, bus_wdata=0x15 stable throughout.
- Read addr 0x1004, slave asserts bus_ready 3 cycles after enable with bus_rdata=0xDEADBEEF. Required: rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_write=0.
- Push 4 back-to-back requests with rsp_ready=1. Required: req_ready falls when 4 entries are queued; responses return in order; bus_enable low for ≥2 cycles between strobes; busy falls only after the last response.
- Slave never asserts ready, TIMEOUT_CYCLES=64. Required: bus_enable drops after 64 ISSUE cycles; rsp_err=1, rsp_rdata=0; the next queued request then proceeds normally.
- Hold rsp_ready=0 for 10 cycles after a response. Required: rsp_valid and rsp_rdata stay stable, bus_enable stays 0, and the queue keeps accepting requests until full.
- Assert rst while in ISSUE with 2 entries queued. Required: bus_enable=0 immediately; no response produced; req_ready=1 and busy=0 after reset release.

Source files
------------

// File: rtl/kyber_bus_master_if.sv
`default_nettype none
// ============================================================================
// Module   : kyber_bus_master_if
// Brief    : Request/response streams and slave bus for kyber_bus_master.
// Revision : 1.0
// ============================================================================
interface kyber_bus_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_write;
  logic        rsp_err;

  logic        bus_enable;
  logic        bus_write;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_write, rsp_err,
    input  rsp_ready,
    output bus_enable, bus_write, bus_addr, bus_wdata,
    input  bus_rdata, bus_ready
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_write, rsp_err,
    output rsp_ready,
    input  bus_enable, bus_write, bus_addr, bus_wdata,
    output bus_rdata, bus_ready
  );
endinterface
`default_nettype wire

// File: rtl/kyber_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : kyber_bus_master
// Brief    : Queued single-outstanding bus master with response timeout.
// Revision : 1.0
// ============================================================================
module kyber_bus_master #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  kyber_bus_master_if.master bif,
  output logic               busy
);

  localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W   = c_PTR_W + 1;
  localparam int c_TMR_W   = $clog2(TIMEOUT_CYCLES);
  localparam int c_ENTRY_W = 65;
  localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(FIFO_DEPTH);
  localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  logic [c_ENTRY_W-1:0] r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;
  logic [c_CNT_W-1:0]   w_count_next;
  logic                 r_req_ready;
  logic                 r_head_avail;
  logic                 w_push;
  logic                 w_pop;
  logic [c_ENTRY_W-1:0] w_head;

  state_t               r_state;
  state_t               w_state_next;
  logic [c_TMR_W-1:0]   r_timer;
  logic [c_TMR_W-1:0]   w_timer_next;
  logic                 r_bus_enable, w_bus_enable;
  logic                 r_bus_write,  w_bus_write;
  logic [31:0]          r_bus_addr,   w_bus_addr;
  logic [31:0]          r_bus_wdata,  w_bus_wdata;
  logic                 r_rsp_valid,  w_rsp_valid;
  logic [31:0]          r_rsp_rdata,  w_rsp_rdata;
  logic                 r_rsp_write,  w_rsp_write;
  logic                 r_rsp_err,    w_rsp_err;

  assign w_push = bif.req_valid && r_req_ready;
  assign w_head = r_mem[r_rd_ptr];

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + c_CNT_W'(1);
      2'b01:   w_count_next = r_count - c_CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  // r_head_avail lags r_count by one cycle. A pop is always followed by at
  // least one ISSUE and one RESP cycle, so IDLE never sees a stale flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_req_ready  <= 1'b1;
      r_head_avail <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      r_count      <= w_count_next;
      r_req_ready  <= (w_count_next != c_DEPTH);
      r_head_avail <= (r_count != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {bif.req_write, bif.req_addr, bif.req_wdata};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_bus_enable <= 1'b0;
      r_bus_write  <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_wdata  <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_write  <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_timer      <= w_timer_next;
      r_bus_enable <= w_bus_enable;
      r_bus_write  <= w_bus_write;
      r_bus_addr   <= w_bus_addr;
      r_bus_wdata  <= w_bus_wdata;
      r_rsp_valid  <= w_rsp_valid;
      r_rsp_rdata  <= w_rsp_rdata;
      r_rsp_write  <= w_rsp_write;
      r_rsp_err    <= w_rsp_err;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_pop        = 1'b0;
    w_bus_enable = r_bus_enable;
    w_bus_write  = r_bus_write;
    w_bus_addr   = r_bus_addr;
    w_bus_wdata  = r_bus_wdata;
    w_rsp_valid  = r_rsp_valid;
    w_rsp_rdata  = r_rsp_rdata;
    w_rsp_write  = r_rsp_write;
    w_rsp_err    = r_rsp_err;
    case (r_state)
      S_IDLE: begin
        w_timer_next = '0;
        w_bus_enable = 1'b0;
        if (r_head_avail) begin
          w_pop        = 1'b1;
          w_bus_enable = 1'b1;
          w_bus_write  = w_head[64];
          w_bus_addr   = w_head[63:32];
          w_bus_wdata  = w_head[31:0];
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_timer_next = r_timer + c_TMR_W'(1);
        // A completion on the final allowed cycle takes priority over timeout.
        if (bif.bus_ready) begin
          w_bus_enable = 1'b0;
          w_rsp_rdata  = r_bus_write ? 32'd0 : bif.bus_rdata;
          w_rsp_write  = r_bus_write;
          w_rsp_err    = 1'b0;
          w_rsp_valid  = 1'b1;
          w_timer_next = '0;
          w_state_next = S_RESP;
        end else if (r_timer == c_TMR_LAST) begin
          w_bus_enable = 1'b0;
          w_rsp_rdata  = 32'd0;
          w_rsp_write  = r_bus_write;
          w_rsp_err    = 1'b1;
          w_rsp_valid  = 1'b1;
          w_timer_next = '0;
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        w_timer_next = '0;
        if (r_rsp_valid && bif.rsp_ready) begin
          w_rsp_valid  = 1'b0;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign bif.req_ready  = r_req_ready;
  assign bif.rsp_valid  = r_rsp_valid;
  assign bif.rsp_rdata  = r_rsp_rdata;
  assign bif.rsp_write  = r_rsp_write;
  assign bif.rsp_err    = r_rsp_err;
  assign bif.bus_enable = r_bus_enable;
  assign bif.bus_write  = r_bus_write;
  assign bif.bus_addr   = r_bus_addr;
  assign bif.bus_wdata  = r_bus_wdata;
  assign busy           = (r_count != '0) || (r_state != S_IDLE);

endmodule
`default_nettype wire
